// File: rtl/pixel_packer_pkg.sv
// Shared definitions for pixel_packer: FSM state encoding and active-low strobe levels.
package pixel_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;

endpackage

// File: rtl/pixel_packer.sv
// Packs a pixel stream into DATA_WIDTH words for a frame buffer whose first two addresses are reserved.
// Define PIXEL_PACKER_FLUSH_EN to zero-pad and emit a partial word at end of frame instead of dropping it.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int PIX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic                  pix_eof,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_ready,
  output logic                  wr_en_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  drop_err
);

  localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
  localparam int LANE_W       = (PIX_PER_WORD > 2) ? $clog2(PIX_PER_WORD) : 1;
  localparam int MEM_DEPTH    = 1 << ADDR_WIDTH;
  localparam int FRAME_WORDS  = MEM_DEPTH - 2;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

  state_t                state;
  logic [LANE_W-1:0]     lane_cnt;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [DATA_WIDTH-1:0] pack_reg;
  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] first_word;
  logic                  xfer;

  assign pix_ready = (state != DONE);
  assign xfer      = pix_valid && pix_ready;

  // pack_reg keeps unfilled lanes at zero, so lane_word is already padded for a flush
  always_comb begin
    lane_word = pack_reg;
    lane_word[int'(lane_cnt) * PIX_WIDTH +: PIX_WIDTH] = pix_data;
    first_word = '0;
    first_word[PIX_WIDTH-1:0] = pix_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lane_cnt   <= '0;
      word_cnt   <= '0;
      pack_reg   <= '0;
      data_out   <= '0;
      wr_en_out  <= DEASSERT_L;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      wr_en_out  <= DEASSERT_L;
      frame_done <= 1'b0;
      case (state)
        IDLE, PACK: begin
          if (xfer) begin
            if (pix_sof) begin
              if ((state == PACK) && (lane_cnt != '0)) drop_err <= 1'b1;
              word_cnt <= '0;
              if (pix_eof) begin
`ifdef PIXEL_PACKER_FLUSH_EN
                data_out  <= first_word;
                wr_en_out <= ASSERT_L;
`endif
                pack_reg   <= '0;
                lane_cnt   <= '0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                pack_reg <= first_word;
                lane_cnt <= LANE_W'(1);
                state    <= PACK;
              end
            end else if (state == IDLE) begin
              drop_err <= 1'b1;
            end else if (lane_cnt == LAST_LANE) begin
              data_out  <= lane_word;
              wr_en_out <= ASSERT_L;
              pack_reg  <= '0;
              lane_cnt  <= '0;
              word_cnt  <= word_cnt + 1'b1;
              if (pix_eof || (word_cnt == LAST_WORD)) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
            end else if (pix_eof) begin
`ifdef PIXEL_PACKER_FLUSH_EN
              data_out  <= lane_word;
              wr_en_out <= ASSERT_L;
`endif
              pack_reg   <= '0;
              lane_cnt   <= '0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              pack_reg <= lane_word;
              lane_cnt <= lane_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          word_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Self-checking bench for pixel_packer: directed vectors, corner sequences and random traffic vs a queue model.
// Expectations follow the PIXEL_PACKER_FLUSH_EN setting of the build.
module tb_pixel_packer;

  localparam int PIX_WIDTH   = 8;
  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 3;
  localparam int PPW         = DATA_WIDTH / PIX_WIDTH;
  localparam int FRAME_WORDS = (1 << ADDR_WIDTH) - 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  pix_valid;
  logic                  pix_sof;
  logic                  pix_eof;
  logic [PIX_WIDTH-1:0]  pix_data;
  logic                  pix_ready;
  logic                  wr_en_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;
  logic                  drop_err;

  int checks = 0;
  int errors = 0;

  bit                    m_in_frame;
  bit                    m_done_cycle;
  bit                    m_drop;
  int                    m_words;
  logic [PIX_WIDTH-1:0]  m_pix[$];
  logic                  exp_wr_n;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  exp_done;

  typedef struct {
    logic                  v;
    logic                  s;
    logic                  e;
    logic [PIX_WIDTH-1:0]  d;
    logic                  wr_n;
    logic [DATA_WIDTH-1:0] data;
    logic                  done;
    logic                  ready;
    logic                  drop;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  pixel_packer #(
    .PIX_WIDTH (PIX_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_eof   (pix_eof),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .wr_en_out (wr_en_out),
    .data_out  (data_out),
    .frame_done(frame_done),
    .drop_err  (drop_err)
  );

  task automatic check(input string name, input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame   = 1'b0;
    m_done_cycle = 1'b0;
    m_drop       = 1'b0;
    m_words      = 0;
    m_pix.delete();
    exp_wr_n = 1'b1;
    exp_data = '0;
    exp_done = 1'b0;
  endtask

  task automatic emit_word();
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < m_pix.size(); i++) w[i*PIX_WIDTH +: PIX_WIDTH] = m_pix[i];
    exp_data = w;
    exp_wr_n = 1'b0;
    m_pix.delete();
  endtask

  // One clock of the frame-level model: pixels accumulate in a queue and leave as whole words.
  task automatic model_step(input bit v, input bit s, input bit e, input logic [PIX_WIDTH-1:0] d);
    bit close;
    close    = 1'b0;
    exp_wr_n = 1'b1;
    exp_done = 1'b0;
    if (m_done_cycle) begin
      m_done_cycle = 1'b0;
      return;
    end
    if (!v) return;
    if (s) begin
      if (m_in_frame && (m_pix.size() != 0)) m_drop = 1'b1;
      m_pix.delete();
      m_words    = 0;
      m_in_frame = 1'b1;
    end else if (!m_in_frame) begin
      m_drop = 1'b1;
      return;
    end
    m_pix.push_back(d);
    if (m_pix.size() == PPW) begin
      emit_word();
      m_words++;
      if (m_words == FRAME_WORDS) close = 1'b1;
    end
    if (e) begin
`ifdef PIXEL_PACKER_FLUSH_EN
      if (m_pix.size() != 0) emit_word();
`endif
      close = 1'b1;
    end
    if (close) begin
      m_in_frame   = 1'b0;
      m_pix.delete();
      m_done_cycle = 1'b1;
      exp_done     = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".wr_en_out"},  wr_en_out,  exp_wr_n);
    check({tag, ".data_out"},   data_out,   exp_data);
    check({tag, ".frame_done"}, frame_done, exp_done);
    check({tag, ".pix_ready"},  pix_ready,  !m_done_cycle);
    check({tag, ".drop_err"},   drop_err,   m_drop);
  endtask

  task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [PIX_WIDTH-1:0] d, input string tag);
    pix_valid = v;
    pix_sof   = s;
    pix_eof   = e;
    pix_data  = d;
    model_step(v, s, e, d);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eof   = 1'b0;
    pix_data  = '0;
    model_reset();

    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 32'h04030201, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 32'h04030201, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h06, 1'b1, 32'h04030201, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 32'h04030201, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 32'h08070605, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'h08070605, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst.wr_en_out",  wr_en_out,  1'b1);
    check("rst.data_out",   data_out,   32'h0);
    check("rst.frame_done", frame_done, 1'b0);
    check("rst.drop_err",   drop_err,   1'b0);
    reset = 1'b0;
    #1;
    check("rst.pix_ready",  pix_ready,  1'b1);

    $display("[TB] directed packing vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_wr", i),    wr_en_out,  vecs[i].wr_n);
      check($sformatf("vec%0d.tbl_data", i),  data_out,   vecs[i].data);
      check($sformatf("vec%0d.tbl_done", i),  frame_done, vecs[i].done);
      check($sformatf("vec%0d.tbl_ready", i), pix_ready,  vecs[i].ready);
      check($sformatf("vec%0d.tbl_drop", i),  drop_err,   vecs[i].drop);
    end

    $display("[TB] full frame of %0d words", FRAME_WORDS);
    for (int i = 0; i < FRAME_WORDS * PPW; i++)
      applyStimulus(1'b1, i == 0, 1'b0, 8'(8'h40 + i), $sformatf("full%0d", i));
    check("full.last_word", data_out,   32'h57565554);
    check("full.wr_low",    wr_en_out,  1'b0);
    check("full.done",      frame_done, 1'b1);
    check("full.not_ready", pix_ready,  1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h99, "full_done_cycle");
    check("full.ready_back", pix_ready, 1'b1);
    check("full.no_drop",    drop_err,  1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "full_idle");

    $display("[TB] end of frame with partial word");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA, "eof0");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hBB, "eof1");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hCC, "eof2");
    check("eof.done", frame_done, 1'b1);
`ifdef PIXEL_PACKER_FLUSH_EN
    check("eof.flush_wr",   wr_en_out, 1'b0);
    check("eof.flush_data", data_out,  32'h00CCBBAA);
`else
    check("eof.no_wr",   wr_en_out, 1'b1);
    check("eof.kept",    data_out,  32'h57565554);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "eof_done");

    $display("[TB] pixel without sof in IDLE");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h77, "drop0");
    check("drop.set", drop_err, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, $sformatf("drop_hold%0d", i));
    check("drop.sticky", drop_err, 1'b1);

    $display("[TB] asynchronous reset mid-word");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h11, "ar0");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h22, "ar1");
    pix_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("ar.wr_en_out",  wr_en_out,  1'b1);
    check("ar.data_out",   data_out,   32'h0);
    check("ar.frame_done", frame_done, 1'b0);
    check("ar.drop_err",   drop_err,   1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "ar_idle0");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "ar_idle1");
    check("ar.no_word", wr_en_out, 1'b1);

    $display("[TB] sof restarts a partial word");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, "rs0");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, "rs1");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, "rs2");
    check("rs.drop", drop_err, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h21, "rs3");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h22, "rs4");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h23, "rs5");
    check("rs.word_wr",   wr_en_out, 1'b0);
    check("rs.word_data", data_out,  32'h23222120);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      bit v, s, e;
      v = ($urandom_range(3) != 0);
      s = ($urandom_range(15) == 0);
      e = ($urandom_range(19) == 0);
      applyStimulus(v, s, e, 8'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
